// File: rtl/pc_gen_unit_pkg.sv
// pc_gen_unit_pkg
//   Shared constants, the next-PC select encoding and the alignment helper
//   used by the program-counter generator and its return-address stack.
//   No ports; imported by pc_gen_unit and pc_gen_unit_ras.
package pc_gen_unit_pkg;

  localparam int STEP_32 = 4;
  localparam int STEP_16 = 2;

  // Next-PC sources, listed from highest to lowest priority.
  typedef enum logic [2:0] {
    SEL_TRAP,
    SEL_MRET,
    SEL_MISALIGN,
    SEL_REDIRECT,
    SEL_STALL,
    SEL_RAS,
    SEL_SEQ
  } pc_sel_e;

  // With compressed instructions only halfword alignment is needed.
  // Without them the target must be word aligned.
  function automatic logic is_misaligned(input logic [1:0] low_bits, input logic c_ext);
    return c_ext ? low_bits[0] : (low_bits != 2'b00);
  endfunction

endpackage

// File: rtl/pc_gen_unit_ras.sv
// pc_gen_unit_ras
//   Circular return-address stack. The top pointer always addresses the
//   most recent entry. The count saturates at RAS_DEPTH, so a push into a
//   full stack silently overwrites the oldest entry.
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   push_en    in   push push_data (combined with pop_en: replace top)
//   pop_en     in   discard top entry (ignored when empty)
//   push_data  in   XLEN address to store
//   top_data   out  most recent entry
//   empty      out  stack holds no entries
import pc_gen_unit_pkg::*;

module pc_gen_unit_ras #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push_en,
  input  logic            pop_en,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top_data,
  output logic            empty
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0]  mem_q [RAS_DEPTH];
  logic [XLEN-1:0]  mem_d [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CNT_W'(RAS_DEPTH));
  assign top_data = mem_q[ptr_q];

  // The pointer wraps for free because RAS_DEPTH is a power of two.
  // A simultaneous push and pop replaces the top entry and leaves the count alone.
  always_comb begin
    mem_d = mem_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push_en && pop_en) begin
      mem_d[ptr_q] = push_data;
    end else if (push_en) begin
      ptr_d        = ptr_q + PTR_W'(1);
      mem_d[ptr_d] = push_data;
      if (!full) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (pop_en && !empty) begin
      ptr_d = ptr_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pc_gen_unit.sv
// pc_gen_unit
//   Program counter for the single-cycle core. Each cycle it picks the next
//   fetch address from one of these sources, in priority order: trap entry,
//   mret, misaligned-redirect trap, redirect, stall hold, RAS prediction,
//   sequential step.
// Ports
//   CLK              in   clock, rising edge
//   Reset            in   asynchronous active-high reset
//   Stall            in   hold PC (overridden by Trap/Mret/Redirect)
//   Redirect         in   taken branch / jal / jalr
//   Redirect_Target  in   redirect address
//   Trap             in   exception / interrupt entry
//   Mret             in   return from trap
//   Is_Compressed    in   current instruction is 16-bit (only when C_EXT=1)
//   Ras_Push         in   push PC_Plus onto the RAS
//   Ras_Pop          in   predict next PC from the RAS top
//   PC               out  current fetch address
//   PC_Plus          out  PC + 2/4, combinational, wraps
//   EPC              out  PC saved at the last trap
//   Misaligned       out  one-cycle pulse after a misaligned redirect
//   Ras_Empty        out  RAS holds no entries
import pc_gen_unit_pkg::*;

module pc_gen_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int              RAS_DEPTH    = 4,
  parameter int              C_EXT        = 0
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic            Stall,
  input  logic            Redirect,
  input  logic [XLEN-1:0] Redirect_Target,
  input  logic            Trap,
  input  logic            Mret,
  input  logic            Is_Compressed,
  input  logic            Ras_Push,
  input  logic            Ras_Pop,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PC_Plus,
  output logic [XLEN-1:0] EPC,
  output logic            Misaligned,
  output logic            Ras_Empty
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic            misaligned_q, misaligned_d;
  logic [XLEN-1:0] step;
  logic [XLEN-1:0] ras_top;
  logic            ras_empty;
  logic            target_bad;
  logic            ras_ok;
  pc_sel_e         sel;

  assign step       = ((C_EXT != 0) && Is_Compressed) ? XLEN'(STEP_16) : XLEN'(STEP_32);
  assign PC_Plus    = pc_q + step;
  assign target_bad = is_misaligned(Redirect_Target[1:0], C_EXT != 0);

  always_comb begin
    sel = SEL_SEQ;
    if (Trap)                         sel = SEL_TRAP;
    else if (Mret)                    sel = SEL_MRET;
    else if (Redirect && target_bad)  sel = SEL_MISALIGN;
    else if (Redirect)                sel = SEL_REDIRECT;
    else if (Stall)                   sel = SEL_STALL;
    else if (Ras_Pop && !ras_empty)   sel = SEL_RAS;
  end

  // The stack is only touched when the instruction actually retires:
  // not stalled, and not displaced by a trap, mret or misaligned trap.
  // An aligned redirect still updates it, because calls and returns are redirects.
  assign ras_ok = !Stall && !(sel inside {SEL_TRAP, SEL_MRET, SEL_MISALIGN});

  always_comb begin
    pc_d         = pc_q;
    epc_d        = epc_q;
    misaligned_d = 1'b0;
    case (sel)
      SEL_TRAP: begin
        pc_d  = TRAP_VECTOR;
        epc_d = pc_q;
      end
      SEL_MRET:     pc_d = epc_q;
      SEL_MISALIGN: begin
        pc_d         = TRAP_VECTOR;
        epc_d        = pc_q;
        misaligned_d = 1'b1;
      end
      SEL_REDIRECT: pc_d = Redirect_Target;
      SEL_STALL:    pc_d = pc_q;
      SEL_RAS:      pc_d = ras_top;
      default:      pc_d = PC_Plus;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      pc_q         <= RESET_VECTOR;
      epc_q        <= '0;
      misaligned_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      epc_q        <= epc_d;
      misaligned_q <= misaligned_d;
    end
  end

  pc_gen_unit_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (CLK),
    .rst       (Reset),
    .push_en   (Ras_Push && ras_ok),
    .pop_en    (Ras_Pop && ras_ok),
    .push_data (PC_Plus),
    .top_data  (ras_top),
    .empty     (ras_empty)
  );

  assign PC         = pc_q;
  assign EPC        = epc_q;
  assign Misaligned = misaligned_q;
  assign Ras_Empty  = ras_empty;

endmodule
